fpu_classify_pipe: RTL and testbench



---
 rtl/fpu_classify_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_fpu_classify_pipe.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_classify_pipe.sv
// -----------------------------------------------------------------------------
// fpu_classify_pipe
//
// Two-stage pipelined IEEE-754 binary32 classifier feeding the FPU compare
// block. Each transaction carries two operands. Both are classified into
// one-hot class words, and the operands travel alongside their classes.
//
// Class word bits (upper 22 bits always zero):
//   0 -inf, 1 -normal, 2 -subnormal, 3 -0, 4 +0, 5 +subnormal,
//   6 +normal, 7 +inf, 8 sNaN, 9 qNaN
//
// Stage 1 captures the operands and the cheap field pre-decodes.
// Stage 2 captures the one-hot classes and the NaN summaries.
// Both stages use valid/ready flow control, and bubbles collapse.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   upstream handshake; in_ready is combinational
//                         from out_ready
//   f_num_a, f_num_b      raw binary32 operands
//   out_valid / out_ready downstream handshake (out_valid is registered)
//   f_num_a_q, f_num_b_q  operands aligned with their classes
//   f_class_a, f_class_b  one-hot class words
//   nan_any, snan_any     either output operand is a NaN / an sNaN
//   nv_clear              clears the sticky invalid flag
//   nv_sticky             sticky invalid flag, set by sNaN handshakes
// -----------------------------------------------------------------------------
module fpu_classify_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] f_num_a,
  input  logic [31:0] f_num_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] f_num_a_q,
  output logic [31:0] f_num_b_q,
  output logic [31:0] f_class_a,
  output logic [31:0] f_class_b,
  output logic        nan_any,
  output logic        snan_any,
  input  logic        nv_clear,
  output logic        nv_sticky
);

  // Bit positions inside a pre-decode vector
  localparam int unsigned PD_SIGN      = 4;
  localparam int unsigned PD_EXP_ONES  = 3;
  localparam int unsigned PD_EXP_ZERO  = 2;
  localparam int unsigned PD_MANT_ZERO = 1;
  localparam int unsigned PD_MANT_MSB  = 0;

  // Class bit positions (shared with the compare unit's class constants)
  localparam int unsigned CLS_NEG_INF  = 0;
  localparam int unsigned CLS_NEG_NORM = 1;
  localparam int unsigned CLS_NEG_SUB  = 2;
  localparam int unsigned CLS_NEG_ZERO = 3;
  localparam int unsigned CLS_POS_ZERO = 4;
  localparam int unsigned CLS_POS_SUB  = 5;
  localparam int unsigned CLS_POS_NORM = 6;
  localparam int unsigned CLS_POS_INF  = 7;
  localparam int unsigned CLS_SNAN     = 8;
  localparam int unsigned CLS_QNAN     = 9;

  // Field pre-decode. These are only wide comparisons, so they sit in
  // stage 1 and keep the class mux in stage 2 shallow.
  function automatic logic [4:0] predecode(input logic [31:0] f);
    logic [4:0] pd;
    pd               = 5'b0;
    pd[PD_SIGN]      = f[31];
    pd[PD_EXP_ONES]  = (f[30:23] == 8'hFF);
    pd[PD_EXP_ZERO]  = (f[30:23] == 8'h00);
    pd[PD_MANT_ZERO] = (f[22:0] == 23'h000000);
    pd[PD_MANT_MSB]  = f[22];
    return pd;
  endfunction

  // One-hot class from the pre-decoded fields. Exactly one bit is set for
  // every encoding. NaN sign is ignored.
  function automatic logic [9:0] classify(input logic [4:0] pd);
    logic [9:0] c;
    c = 10'b0;
    if (pd[PD_EXP_ONES]) begin
      if (pd[PD_MANT_ZERO]) begin
        if (pd[PD_SIGN]) c[CLS_NEG_INF] = 1'b1;
        else             c[CLS_POS_INF] = 1'b1;
      end else if (pd[PD_MANT_MSB]) begin
        c[CLS_QNAN] = 1'b1;
      end else begin
        c[CLS_SNAN] = 1'b1;
      end
    end else if (pd[PD_EXP_ZERO]) begin
      if (pd[PD_MANT_ZERO]) begin
        if (pd[PD_SIGN]) c[CLS_NEG_ZERO] = 1'b1;
        else             c[CLS_POS_ZERO] = 1'b1;
      end else begin
        if (pd[PD_SIGN]) c[CLS_NEG_SUB] = 1'b1;
        else             c[CLS_POS_SUB] = 1'b1;
      end
    end else begin
      if (pd[PD_SIGN]) c[CLS_NEG_NORM] = 1'b1;
      else             c[CLS_POS_NORM] = 1'b1;
    end
    return c;
  endfunction

  // Stage 1 state
  logic        s1_v_r;
  logic [31:0] s1_a_r;
  logic [31:0] s1_b_r;
  logic [4:0]  s1_pd_a_r;
  logic [4:0]  s1_pd_b_r;

  // Stage 2 state
  logic        s2_v_r;
  logic [31:0] s2_a_r;
  logic [31:0] s2_b_r;
  logic [9:0]  s2_cls_a_r;
  logic [9:0]  s2_cls_b_r;
  logic        s2_nan_r;
  logic        s2_snan_r;
  logic        nv_sticky_r;

  // Flow control and stage-2 next-state values
  logic        s1_adv_s;
  logic        s2_adv_s;
  logic [9:0]  cls_a_s;
  logic [9:0]  cls_b_s;
  logic        nan_s;
  logic        snan_s;
  logic        nv_set_s;

  // A stage advances when it is empty or its successor advances. The ready
  // chain therefore ripples back from out_ready, which lets bubbles collapse.
  assign s2_adv_s = !s2_v_r || out_ready;
  assign s1_adv_s = !s1_v_r || s2_adv_s;
  assign in_ready = s1_adv_s;

  // Stage 2 combinational classification of the stage-1 contents
  always_comb begin
    cls_a_s  = classify(s1_pd_a_r);
    cls_b_s  = classify(s1_pd_b_r);
    nan_s    = cls_a_s[CLS_SNAN] | cls_a_s[CLS_QNAN] |
               cls_b_s[CLS_SNAN] | cls_b_s[CLS_QNAN];
    snan_s   = cls_a_s[CLS_SNAN] | cls_b_s[CLS_SNAN];
    nv_set_s = s2_v_r && out_ready && s2_snan_r;
  end

  // Stage 1 register: operands plus field pre-decode, loaded on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_r    <= 1'b0;
      s1_a_r    <= 32'h0;
      s1_b_r    <= 32'h0;
      s1_pd_a_r <= 5'b0;
      s1_pd_b_r <= 5'b0;
    end else if (s1_adv_s) begin
      s1_v_r <= in_valid;
      if (in_valid) begin
        s1_a_r    <= f_num_a;
        s1_b_r    <= f_num_b;
        s1_pd_a_r <= predecode(f_num_a);
        s1_pd_b_r <= predecode(f_num_b);
      end
    end
  end

  // Stage 2 register: data only loads when a valid pair moves in, so the
  // outputs stay stable while the downstream side stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v_r     <= 1'b0;
      s2_a_r     <= 32'h0;
      s2_b_r     <= 32'h0;
      s2_cls_a_r <= 10'b0;
      s2_cls_b_r <= 10'b0;
      s2_nan_r   <= 1'b0;
      s2_snan_r  <= 1'b0;
    end else if (s2_adv_s) begin
      s2_v_r <= s1_v_r;
      if (s1_v_r) begin
        s2_a_r     <= s1_a_r;
        s2_b_r     <= s1_b_r;
        s2_cls_a_r <= cls_a_s;
        s2_cls_b_r <= cls_b_s;
        s2_nan_r   <= nan_s;
        s2_snan_r  <= snan_s;
      end
    end
  end

  // Sticky invalid flag: an sNaN handshake beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nv_sticky_r <= 1'b0;
    end else if (nv_set_s) begin
      nv_sticky_r <= 1'b1;
    end else if (nv_clear) begin
      nv_sticky_r <= 1'b0;
    end
  end

  assign out_valid = s2_v_r;
  assign f_num_a_q = s2_a_r;
  assign f_num_b_q = s2_b_r;
  assign f_class_a = {22'h0, s2_cls_a_r};
  assign f_class_b = {22'h0, s2_cls_b_r};
  assign nan_any   = s2_nan_r;
  assign snan_any  = s2_snan_r;
  assign nv_sticky = nv_sticky_r;

endmodule

// File: tb/tb_fpu_classify_pipe.sv
// -----------------------------------------------------------------------------
// tb_fpu_classify_pipe
//
// Scoreboard bench for fpu_classify_pipe. The driver pushes the hand-computed
// expected response when a pair is accepted. The monitor compares the head of
// the queue on every cycle with out_valid and pops it on a handshake.
// -----------------------------------------------------------------------------
module tb_fpu_classify_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] f_num_a = 32'h0;
  logic [31:0] f_num_b = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] f_num_a_q;
  logic [31:0] f_num_b_q;
  logic [31:0] f_class_a;
  logic [31:0] f_class_b;
  logic        nan_any;
  logic        snan_any;
  logic        nv_clear = 1'b0;
  logic        nv_sticky;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ca;
    logic [31:0] cb;
    logic        nan;
    logic        snan;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   hs_count = 0;
  int   w0, w1, w2, w3;

  fpu_classify_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .f_num_a   (f_num_a),
    .f_num_b   (f_num_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f_num_a_q (f_num_a_q),
    .f_num_b_q (f_num_b_q),
    .f_class_a (f_class_a),
    .f_class_b (f_class_b),
    .nan_any   (nan_any),
    .snan_any  (snan_any),
    .nv_clear  (nv_clear),
    .nv_sticky (nv_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a pair, wait (bounded) for acceptance, and record the expectation.
  // Returns one posedge+1 after the accepting edge, with in_valid still high.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [9:0] ca, input logic [9:0] cb, output int waits);
    exp_t e;
    waits = 0;
    f_num_a  = a;
    f_num_b  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b0;
    end else begin
      e.a    = a;
      e.b    = b;
      e.ca   = {22'h0, ca};
      e.cb   = {22'h0, cb};
      e.nan  = |(ca[9:8] | cb[9:8]);
      e.snan = ca[8] | cb[8];
      sb_q.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  // Wait (bounded) until every expected pair has been handed off
  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", {63'd0, (sb_q.size() == 0)}, 64'd1);
  endtask

  // Monitor: compare each presented pair against the scoreboard head
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_output", {63'd0, out_valid}, 64'd0);
      end else begin
        chk("f_num_a_q", {32'h0, f_num_a_q}, {32'h0, sb_q[0].a});
        chk("f_num_b_q", {32'h0, f_num_b_q}, {32'h0, sb_q[0].b});
        chk("f_class_a", {32'h0, f_class_a}, {32'h0, sb_q[0].ca});
        chk("f_class_b", {32'h0, f_class_b}, {32'h0, sb_q[0].cb});
        chk("nan_any",   {63'd0, nan_any},   {63'd0, sb_q[0].nan});
        chk("snan_any",  {63'd0, snan_any},  {63'd0, sb_q[0].snan});
        if (out_ready) begin
          void'(sb_q.pop_front());
          hs_count++;
        end
      end
    end
  end

  logic [31:0] sweep_v [8];
  logic [9:0]  sweep_c [8];

  initial begin
    int wt;
    int hs_before;
    sweep_v = '{32'hFF800000, 32'hBF800000, 32'h80000001, 32'h80000000,
                32'h00000000, 32'h00000001, 32'h3F800000, 32'h7FC00000};
    sweep_c = '{10'h001, 10'h002, 10'h004, 10'h008,
                10'h010, 10'h020, 10'h040, 10'h200};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_class",     {f_class_a, f_class_b}, 64'd0);
    chk("rst_num_q",     {f_num_a_q, f_num_b_q}, 64'd0);
    chk("rst_flags",     {61'd0, nan_any, snan_any, nv_sticky}, 64'd0);
    @(posedge clk);
    #1;

    // Single pair: +inf and sNaN, with the two-cycle latency checked
    send(32'h7F800000, 32'hFF800001, 10'h080, 10'h100, wt);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1_invalid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk);
    #1;
    chk("sticky_set", {63'd0, nv_sticky}, 64'd1);
    nv_clear = 1'b1;
    @(posedge clk);
    #1;
    nv_clear = 1'b0;
    chk("sticky_cleared", {63'd0, nv_sticky}, 64'd0);

    // Full encoding sweep, back to back, no stalls expected
    for (int i = 0; i < 8; i++) begin
      send(sweep_v[i], sweep_v[(i + 1) % 8], sweep_c[i], sweep_c[(i + 1) % 8], wt);
      chk("sweep_no_stall", wt, 64'd0);
    end
    in_valid = 1'b0;
    wait_drain();

    // Backpressure: 4 pairs with out_ready low for 5 cycles
    out_ready = 1'b0;
    fork
      begin
        send(32'h3F800000, 32'hBF800000, 10'h040, 10'h002, w0);
        send(32'h00000001, 32'h80000000, 10'h020, 10'h008, w1);
        send(32'hFF800000, 32'h7F800000, 10'h001, 10'h080, w2);
        send(32'h7FC00000, 32'h80000001, 10'h200, 10'h004, w3);
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    chk("bp_first_two_accept", {32'h0, w0, w1}, 64'd0);
    chk("bp_in_ready_fell", {63'd0, (w2 > 0)}, 64'd1);
    wait_drain();

    // Sticky priority: clear in the same cycle as an sNaN handshake
    send(32'h7F800001, 32'h3F800000, 10'h100, 10'h040, wt);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("prio_hs_cycle", {63'd0, out_valid}, 64'd1);
    nv_clear = 1'b1;
    @(posedge clk);
    #1;
    nv_clear = 1'b0;
    chk("prio_set_wins", {63'd0, nv_sticky}, 64'd1);
    nv_clear = 1'b1;
    @(posedge clk);
    #1;
    nv_clear = 1'b0;
    chk("prio_clear_next", {63'd0, nv_sticky}, 64'd0);

    // qNaN only: NaN flagged, sticky untouched
    send(32'h7FC00000, 32'h3F800000, 10'h200, 10'h040, wt);
    in_valid = 1'b0;
    wait_drain();
    chk("qnan_no_sticky", {63'd0, nv_sticky}, 64'd0);

    // Reset mid-flight: first set the sticky flag, then fill the pipe
    send(32'h7F800001, 32'h00000000, 10'h100, 10'h010, wt);
    in_valid = 1'b0;
    wait_drain();
    chk("pre_rst_sticky", {63'd0, nv_sticky}, 64'd1);
    out_ready = 1'b0;
    send(32'h3F800000, 32'h00000001, 10'h040, 10'h020, wt);
    send(32'hBF800000, 32'h80000000, 10'h002, 10'h008, wt);
    in_valid = 1'b0;
    chk("pre_rst_full", {63'd0, in_ready}, 64'd0);
    hs_before = hs_count;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_drops_valid", {63'd0, out_valid}, 64'd0);
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_no_handshake", hs_count, hs_before);
    chk("rst_in_ready",     {63'd0, in_ready},  64'd1);
    chk("rst_sticky",       {63'd0, nv_sticky}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
